// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, receiver/transmitter state encoding
// and the 2-of-3 vote used by the optional glitch filter.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } uart_state_e;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line and FIFO status in, received byte and
// status strobes out. The slave modport is the receiver's view.
interface uart_rx_if;
  import uart_pkg::*;

  logic                      rx;
  logic                      full;
  logic [UART_DATA_BITS-1:0] data;
  logic                      write;
  logic                      frame_err;
  logic                      overrun;

  modport master (
    output rx,
    output full,
    input  data,
    input  write,
    input  frame_err,
    input  overrun
  );

  modport slave (
    input  rx,
    input  full,
    output data,
    output write,
    output frame_err,
    output overrun
  );

endinterface

// File: rtl/sync2.sv
// Generic two-flop synchronizer for asynchronous pin inputs; both flops
// reset to ResetVal so an idle line does not look like an edge after reset.
module sync2 #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_q <= {2{ResetVal}};
    end else begin
      ff_q <= {ff_q[0], d_i};
    end
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8n1 UART receiver with oversampled bit timing and FIFO write/overrun strobes.
// Define UART_RX_MAJORITY_EN to take a 2-of-3 vote at every sample point.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16
) (
  input logic     clk,
  input logic     rst_n,
  uart_rx_if.slave uart_io
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam logic [CntW-1:0] HalfM1 = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] FullM1 = CntW'(OVERSAMPLE - 1);
  localparam logic [2:0] LastBit = 3'(UART_DATA_BITS - 1);

  if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_oversample
    $error("uart_rx: OVERSAMPLE must be even and >= 4");
  end

  logic in_s;
  logic line_now;
  logic smp;

  sync2 #(
    .ResetVal (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (uart_io.rx),
    .q_o   (in_s)
  );

  // One register stage sits between the synchronizer and all FSM decisions in
  // both builds, so the voted and single-sample variants share identical timing.
`ifdef UART_RX_MAJORITY_EN
  logic [2:0] hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 3'b111;
    end else begin
      hist_q <= {hist_q[1:0], in_s};
    end
  end

  assign line_now = hist_q[0];
  assign smp      = maj3(hist_q);
`else
  logic line_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= 1'b1;
    end else begin
      line_q <= in_s;
    end
  end

  assign line_now = line_q;
  assign smp      = line_q;
`endif

  uart_state_e               state_q;
  logic [CntW-1:0]           cnt_q;
  logic [2:0]                bitn_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [UART_DATA_BITS-1:0] data_q;
  logic                      write_q;
  logic                      ferr_q;
  logic                      ovr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bitn_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      write_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!line_now) begin
            state_q <= StStart;
            cnt_q   <= '0;
          end
        end
        StStart: begin
          if (cnt_q == HalfM1) begin
            if (smp) begin
              state_q <= StIdle;
            end else begin
              state_q <= StData;
              cnt_q   <= '0;
              bitn_q  <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          if (cnt_q == FullM1) begin
            cnt_q   <= '0;
            shift_q <= {smp, shift_q[UART_DATA_BITS-1:1]};
            bitn_q  <= bitn_q + 3'd1;
            if (bitn_q == LastBit) begin
              state_q <= StStop;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StStop: begin
          // Leave at the stop-bit midpoint to gain half a bit of resync margin.
          if (cnt_q == FullM1) begin
            if (!smp) begin
              ferr_q  <= 1'b1;
              state_q <= StBreak;
            end else if (uart_io.full) begin
              ovr_q   <= 1'b1;
              state_q <= StIdle;
            end else begin
              data_q  <= shift_q;
              write_q <= 1'b1;
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StBreak: begin
          if (line_now) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign uart_io.data      = data_q;
  assign uart_io.write     = write_q;
  assign uart_io.frame_err = ferr_q;
  assign uart_io.overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: the driver predicts each frame's outcome from
// the 8n1 rules and a monitor compares every strobe against the queue.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned OS  = 16;
  localparam int          LAT = OS / 2 + 9 * OS + 3;

  typedef enum int {EvWrite = 0, EvFerr = 1, EvOvr = 2} ev_e;
  typedef struct {
    ev_e        kind;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [7:0] last_data = 8'h00;
  exp_t sb_q[$];
  exp_t mon_e;

  uart_rx_if bus ();

  uart_rx #(
    .OVERSAMPLE (OS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .uart_io (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one full frame starting at a negedge; glitch inverts the line for
  // the single cycle that lands on each bit's sample point.
  task automatic send(input logic [7:0] b, input logic stop, input logic full_v,
                      input bit glitch);
    exp_t e;
    logic v;
    e.cyc  = cyc + 1 + LAT;
    e.data = b;
    if (!stop)       e.kind = EvFerr;
    else if (full_v) e.kind = EvOvr;
    else             e.kind = EvWrite;
    sb_q.push_back(e);
    bus.full = full_v;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      v = 1'b0;
      else if (k <= 8) v = b[k-1];
      else             v = stop;
      for (int c = 0; c < int'(OS); c++) begin
        bus.rx = (glitch && c == int'(OS / 2)) ? ~v : v;
        @(negedge clk);
      end
    end
    bus.full = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && (bus.write || bus.frame_err || bus.overrun)) begin
      check("pulse_onehot", $countones({bus.write, bus.frame_err, bus.overrun}), 1);
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got w/fe/ov=%b%b%b at cycle %0d, expected none",
                 bus.write, bus.frame_err, bus.overrun, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("pulse_kind", bus.write ? 0 : (bus.frame_err ? 1 : 2), mon_e.kind);
        check("pulse_cycle", cyc, mon_e.cyc);
        if (mon_e.kind == EvWrite) begin
          check("rx_data", bus.data, mon_e.data);
          last_data = mon_e.data;
        end else begin
          check("data_hold", bus.data, last_data);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rb;
    logic       rs;
    logic       rf;
    bus.rx   = 1'b1;
    bus.full = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data", bus.data, 8'h00);
    check("reset_write", bus.write, 0);
    check("reset_ferr", bus.frame_err, 0);
    check("reset_ovr", bus.overrun, 0);
    rst_n = 1'b1;
    idle(2 * OS);

    send(8'hA5, 1'b1, 1'b0, 1'b0);
    idle(OS);

    // Back-to-back, no idle gap: pulses land 160 cycles apart.
    send(8'h00, 1'b1, 1'b0, 1'b0);
    send(8'hFF, 1'b1, 1'b0, 1'b0);
    idle(OS);

    bus.rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(2 * OS);
    send(8'h3C, 1'b1, 1'b0, 1'b0);
    idle(OS);

    send(8'h55, 1'b0, 1'b0, 1'b0);
    bus.rx = 1'b0;
    repeat (40 * OS) @(negedge clk);
    idle(2 * OS);
    send(8'h12, 1'b1, 1'b0, 1'b0);
    idle(OS);

    send(8'h7E, 1'b1, 1'b1, 1'b0);
    idle(OS);

    // Abort 0x99 halfway through data bit 4 with a 3-cycle reset.
    bus.rx = 1'b0;
    repeat (OS) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      bus.rx = rb_bit(8'h99, k);
      repeat (OS) @(negedge clk);
    end
    bus.rx = rb_bit(8'h99, 4);
    repeat (OS / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_data", bus.data, 8'h00);
    check("midreset_write", bus.write, 0);
    check("midreset_ferr", bus.frame_err, 0);
    check("midreset_ovr", bus.overrun, 0);
    last_data = 8'h00;
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2 * OS);
    send(8'h81, 1'b1, 1'b0, 1'b0);
    idle(OS);

`ifdef UART_RX_MAJORITY_EN
    send(8'h81, 1'b1, 1'b0, 1'b1);
    idle(OS);
`endif

    for (int i = 0; i < 40; i++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 7) != 0);
      rf = ($urandom_range(0, 3) == 0);
      send(rb, rs, rf, 1'b0);
      if (!rs) idle(int'(OS) + int'($urandom_range(0, 20)));
      else     idle(int'($urandom_range(0, 20)));
    end

    idle(4 * OS);
    check("scoreboard_empty", sb_q.size(), 0);
    check("final_data", bus.data, last_data);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic logic rb_bit(input logic [7:0] b, input int k);
    return b[k];
  endfunction

endmodule

// File: doc/uart_rx.md
# uart_rx

- Receives 8n1 UART frames on `in`, LSB first.
- Samples the line with an oversampling clock and reports each received byte with a one-cycle `write` pulse.
- Sits between a physical input pin and an external FIFO (n = 8): `write` drives the FIFO write strobe, `full` is the FIFO's full status.
- Pairs with `uart_tx` as the receive half of the same link.

## Interface
- `OVERSAMPLE`, default 16: `clk` cycles per UART bit. Must be even and ≥ 4; elaboration error otherwise.
- `clk`  input  1  oversampling clock, frequency = baud × `OVERSAMPLE`.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in`  input  1  UART line; asynchronous to `clk`, idle high.
- `full`  input  1  high = downstream FIFO cannot accept a byte.
- `data`  output  8  last received byte; held until the next successful receive.
- `write`  output  1  one-cycle pulse; `data` is valid in the same cycle.
- `frame_err`  output  1  one-cycle pulse when the stop bit samples low.
- `overrun`  output  1  one-cycle pulse when a good byte arrives while `full` is high.

## Operation
- `in` passes through a 2-FF synchronizer; both flops reset to 1. The synchronized signal is `in_s`.
- `cnt` is a bit-phase counter of width clog2(`OVERSAMPLE`). `bitn` is a 3-bit data-bit index.
- IDLE:
  - `in_s` = 0 → START, `cnt` = 0.
- START:
  - `cnt` increments each cycle.
  - At `cnt` = `OVERSAMPLE`/2−1, sample the line.
  - Sample 1 → false start, return to IDLE, no output.
  - Sample 0 → DATA, `cnt` = 0, `bitn` = 0.
- DATA:
  - At `cnt` = `OVERSAMPLE`−1, sample the line, shift it into the MSB of the shift register (LSB-first reception), `cnt` = 0, `bitn` += 1.
  - After bit 7 → STOP.
- STOP, sample taken at `cnt` = `OVERSAMPLE`−1:
  - Sample 1 and `full` = 0: `data` ← shift register, pulse `write`, go to IDLE.
  - Sample 1 and `full` = 1: pulse `overrun`; `data` and `write` unchanged; go to IDLE.
  - Sample 0: pulse `frame_err`, no `write`, go to BREAK.
- BREAK:
  - Wait for `in_s` = 1, then go to IDLE. A held-low line (break) yields exactly one `frame_err`.
- Return to IDLE at the stop-bit midpoint. This gives half a bit of margin to resynchronize on back-to-back frames.
- `write`, `frame_err` and `overrun` are mutually exclusive; at most one pulses per frame.
- Asserting `rst_n` mid-frame:
  - state → IDLE, all outputs and `data` → 0, synchronizer → 1.
  - The partially received frame is discarded.
  - The first byte accepted after release must begin with a fresh falling edge.

## Timing
- Reset values: `data` = 0x00, `write` = 0, `frame_err` = 0, `overrun` = 0.
- Cycle 0 is the first `clk` edge that samples `in` low.
- `write`, `frame_err` and `overrun` pulse exactly `OVERSAMPLE`/2 + 9·`OVERSAMPLE` + 3 cycles after cycle 0. That is 155 for `OVERSAMPLE` = 16.
- `full` is sampled only in the stop-bit sample cycle.
- A following start edge may be detected as early as the cycle after the pulse.
- All outputs are registered; there are no combinational paths from `in` or `full`.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Each sample point takes the 2-of-3 majority of `in_s` over the sample cycle and the two preceding cycles (3-bit history register).
  - Rejects single-cycle glitches.
  - Latency is unchanged.
- Undefined: each sample point uses the single `in_s` value. No history register.

## Structure
- Shared package `uart_pkg`:
  - state enum IDLE/START/DATA/STOP/BREAK.
  - `UART_DATA_BITS` = 8.
  - This package is shared with the transmitter.
- Sub-module `sync2`: generic 2-FF synchronizer with a reset-value parameter (1 here). Reused elsewhere for pin inputs.

## Test plan
- Byte 0xA5, 8n1, `OVERSAMPLE` = 16, `full` = 0 → single `write` 155 cycles after start edge, `data` = 0xA5, no error pulses.
- Back-to-back 0x00 then 0xFF, no idle gap → two `write` pulses 160 cycles apart, `data` 0x00 then 0xFF.
- 4-cycle low glitch on idle line → false start, no output pulses; next valid 0x3C received correctly.
- Frame 0x55 with stop bit low, line then held low for 40 bit times → one `frame_err`, no `write`; after line returns high, 0x12 received normally.
- `full` = 1 during stop bit of 0x7E → `overrun` pulse, `write` stays 0, `data` keeps previous byte.
- `rst_n` low for 3 cycles at data bit 4 of 0x99 → outputs 0 immediately, no pulse for that frame; the following 0x81 is received correctly. With `UART_RX_MAJORITY_EN`, a 1-cycle inverted glitch at each sample point still yields 0x81.
